// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode field width and constants, default instruction
// width, and the fetch-stage state encoding.
package isa_pkg;

    localparam int OPCODE_W        = 4;
    localparam int INSTR_W_DEFAULT = 24;

    localparam logic [OPCODE_W-1:0] OP_MUL  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_MULI = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_DIVI = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LDR  = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_STR  = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_B    = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 4'h8;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        FULL    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time and
// holds the returned word in a one-entry instruction register for the decoder.
//
// state   | meaning
// FETCH   | idle, request pc this cycle unless a branch redirects
// WAIT    | request outstanding, waiting for imemValid
// FULL    | instruction register live, waiting for instrReady
// DISCARD | outstanding response is stale (branch seen), drop it on arrival
module instruction_fetch
    import isa_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = INSTR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imemReq,
    output logic [ADDR_W-1:0]   imemAddr,
    input  logic [INSTR_W-1:0]  imemRdata,
    input  logic                imemValid,
    input  logic                branchTaken,
    input  logic [ADDR_W-1:0]   branchTarget,
    input  logic                instrReady,
    output logic                instrValid,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   pcOut
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;

    // Ready and branch reach the request strobe combinationally so a consumed
    // instruction is replaced without a bubble cycle.
    assign imemReq  = ((state == FETCH) || ((state == FULL) && instrReady)) && !branchTaken;
    assign imemAddr = pc;
    assign opcode   = instr[INSTR_W-1 -: OPCODE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instrValid <= 1'b0;
            instr      <= '0;
            pcOut      <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (branchTaken) begin
                        pc <= branchTarget;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (branchTaken) begin
                        pc    <= branchTarget;
                        state <= imemValid ? FETCH : DISCARD;
                    end else if (imemValid) begin
                        instr      <= imemRdata;
                        pcOut      <= pc;
                        pc         <= pc + ADDR_W'(1);
                        instrValid <= 1'b1;
                        state      <= FULL;
                    end
                end
                DISCARD: begin
                    if (branchTaken) begin
                        pc <= branchTarget;
                    end
                    if (imemValid) begin
                        state <= FETCH;
                    end
                end
                FULL: begin
                    if (branchTaken) begin
                        instrValid <= 1'b0;
                        pc         <= branchTarget;
                        state      <= FETCH;
                    end else if (instrReady) begin
                        instrValid <= 1'b0;
                        state      <= WAIT;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, stall, branch/discard
// handling, and PC wrap from a 0xFFFF reset vector with reset mid-request.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic [23:0] imemRdata;
    logic        imemValid;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic        instrReady;
    logic        instrValid;
    logic [23:0] instr;
    logic [3:0]  opcode;
    logic [15:0] pcOut;

    logic        rst2_n;
    logic        req2;
    logic [15:0] addr2;
    logic [23:0] rdata2;
    logic        valid2;
    logic        ready2;
    logic        ivalid2;
    logic [23:0] instr2;
    logic [3:0]  opcode2;
    logic [15:0] pcout2;

    int checks   = 0;
    int failures = 0;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemRdata(imemRdata), .imemValid(imemValid), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .instrReady(instrReady), .instrValid(instrValid),
        .instr(instr), .opcode(opcode), .pcOut(pcOut)
    );

    instruction_fetch #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imemReq(req2), .imemAddr(addr2),
        .imemRdata(rdata2), .imemValid(valid2), .branchTaken(1'b0),
        .branchTarget(16'h0000), .instrReady(ready2), .instrValid(ivalid2),
        .instr(instr2), .opcode(opcode2), .pcOut(pcout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imemValid = 1'b0; imemRdata = '0; branchTaken = 1'b0;
        branchTarget = '0; instrReady = 1'b0;
        step(); step();
        checks++;
        if (instrValid !== 1'b0 || instr !== 24'h0 || pcOut !== 16'h0) begin
            failures++;
            $display("FAIL reset_regs: valid=%b instr=%h pcOut=%h required 0/0/0", instrValid, instr, pcOut);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imemReq !== 1'b1 || imemAddr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_first_req: req=%b addr=%h required 1/0000", imemReq, imemAddr);
        end
        step();
        imemValid = 1'b1; imemRdata = 24'h4A0000;
        step();
        imemValid = 1'b0;
        #1;
        checks++;
        if (instrValid !== 1'b1 || opcode !== 4'h4 || pcOut !== 16'h0000 || instr !== 24'h4A0000) begin
            failures++;
            $display("FAIL first_instr: valid=%b op=%h pcOut=%h instr=%h required 1/4/0000/4a0000",
                     instrValid, opcode, pcOut, instr);
        end
        checks++;
        if (imemReq !== 1'b0) begin
            failures++;
            $display("FAIL full_no_ready_req: req=%b required 0", imemReq);
        end
    endtask

    task automatic test_stream();
        instrReady = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++;
            if (imemReq !== 1'b1 || imemAddr !== 16'(i)) begin
                failures++;
                $display("FAIL stream_req[%0d]: req=%b addr=%h required 1/%h", i, imemReq, imemAddr, 16'(i));
            end
            step();
            checks++;
            if (instrValid !== 1'b0 || imemReq !== 1'b0) begin
                failures++;
                $display("FAIL stream_wait[%0d]: valid=%b req=%b required 0/0", i, instrValid, imemReq);
            end
            imemValid = 1'b1; imemRdata = {4'(i), 20'(i)};
            step();
            imemValid = 1'b0;
            checks++;
            if (instrValid !== 1'b1 || pcOut !== 16'(i) || opcode !== 4'(i)) begin
                failures++;
                $display("FAIL stream_full[%0d]: valid=%b pcOut=%h op=%h required 1/%h/%h",
                         i, instrValid, pcOut, opcode, 16'(i), 4'(i));
            end
        end
    endtask

    task automatic test_stall();
        instrReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (imemReq !== 1'b0 || pcOut !== 16'h0003 || instr !== 24'h300003 || instrValid !== 1'b1) begin
                failures++;
                $display("FAIL stall[%0d]: req=%b pcOut=%h instr=%h valid=%b required 0/0003/300003/1",
                         i, imemReq, pcOut, instr, instrValid);
            end
            step();
        end
        instrReady = 1'b1;
        #1;
        checks++;
        if (imemReq !== 1'b1 || imemAddr !== 16'h0004) begin
            failures++;
            $display("FAIL stall_release: req=%b addr=%h required 1/0004", imemReq, imemAddr);
        end
        step();
    endtask

    task automatic test_branch_discard();
        branchTaken = 1'b1; branchTarget = 16'h0040;
        #1;
        checks++;
        if (imemReq !== 1'b0) begin
            failures++;
            $display("FAIL discard_branch_req: req=%b required 0", imemReq);
        end
        step();
        branchTaken = 1'b0;
        step();
        imemValid = 1'b1; imemRdata = 24'hFFFFFF;
        #1;
        checks++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
            failures++;
            $display("FAIL discard_wait: req=%b valid=%b required 0/0", imemReq, instrValid);
        end
        step();
        imemValid = 1'b0;
        #1;
        checks++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 16'h0040) begin
            failures++;
            $display("FAIL discard_redirect: valid=%b req=%b addr=%h required 0/1/0040",
                     instrValid, imemReq, imemAddr);
        end
    endtask

    task automatic test_branch_with_valid();
        step();
        imemValid = 1'b1; imemRdata = 24'h123456; branchTaken = 1'b1; branchTarget = 16'h0040;
        step();
        imemValid = 1'b0; branchTaken = 1'b0;
        #1;
        checks++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 16'h0040) begin
            failures++;
            $display("FAIL branch_valid_drop: valid=%b req=%b addr=%h required 0/1/0040",
                     instrValid, imemReq, imemAddr);
        end
        step();
        imemValid = 1'b1; imemRdata = 24'h7ABCDE;
        step();
        imemValid = 1'b0;
        checks++;
        if (instrValid !== 1'b1 || pcOut !== 16'h0040 || opcode !== 4'h7) begin
            failures++;
            $display("FAIL branch_refetch: valid=%b pcOut=%h op=%h required 1/0040/7", instrValid, pcOut, opcode);
        end
        branchTaken = 1'b1; branchTarget = 16'h0020;
        #1;
        checks++;
        if (imemReq !== 1'b0) begin
            failures++;
            $display("FAIL full_branch_req: req=%b required 0", imemReq);
        end
        step();
        branchTaken = 1'b0;
        #1;
        checks++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 16'h0020) begin
            failures++;
            $display("FAIL full_branch_redirect: valid=%b req=%b addr=%h required 0/1/0020",
                     instrValid, imemReq, imemAddr);
        end
    endtask

    task automatic test_wrap_and_reset();
        rst2_n = 1'b1;
        #1;
        checks++;
        if (req2 !== 1'b1 || addr2 !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_first_req: req=%b addr=%h required 1/ffff", req2, addr2);
        end
        step();
        valid2 = 1'b1; rdata2 = 24'h812345;
        step();
        valid2 = 1'b0;
        checks++;
        if (ivalid2 !== 1'b1 || pcout2 !== 16'hFFFF || opcode2 !== 4'h8) begin
            failures++;
            $display("FAIL wrap_full: valid=%b pcOut=%h op=%h required 1/ffff/8", ivalid2, pcout2, opcode2);
        end
        ready2 = 1'b1;
        #1;
        checks++;
        if (req2 !== 1'b1 || addr2 !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_next_req: req=%b addr=%h required 1/0000", req2, addr2);
        end
        step();
        ready2 = 1'b0;
        rst2_n = 1'b0;
        #1;
        checks++;
        if (ivalid2 !== 1'b0 || instr2 !== 24'h0 || pcout2 !== 16'h0 || addr2 !== 16'hFFFF) begin
            failures++;
            $display("FAIL mid_wait_reset: valid=%b instr=%h pcOut=%h addr=%h required 0/0/0/ffff",
                     ivalid2, instr2, pcout2, addr2);
        end
        step();
        rst2_n = 1'b1;
        valid2 = 1'b1; rdata2 = 24'h5AAAAA;
        #1;
        checks++;
        if (req2 !== 1'b1 || addr2 !== 16'hFFFF) begin
            failures++;
            $display("FAIL post_reset_req: req=%b addr=%h required 1/ffff", req2, addr2);
        end
        step();
        valid2 = 1'b0;
        step();
        checks++;
        if (ivalid2 !== 1'b0 || pcout2 !== 16'h0) begin
            failures++;
            $display("FAIL late_resp_ignored: valid=%b pcOut=%h required 0/0000", ivalid2, pcout2);
        end
    endtask

    initial begin
        rst2_n = 1'b0; valid2 = 1'b0; rdata2 = '0; ready2 = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_branch_discard();
        test_branch_with_valid();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
